pattern_player: RTL and testbench
=================================

PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 The block SHALL have parameter NOTE_W, default 4, bits per note code.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, number of note slots.
REQ-003 The block SHALL have parameter PERIOD_W, default 32, width of the hold and gap timers.
REQ-004 The block SHALL derive LEN_W = clog2(MAX_LEN+1) internally.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- level_data  input  NOTE_W*MAX_LEN  packed note slots; slot 0 in the most-significant NOTE_W bits.
- level_length  input  LEN_W  number of slots to play.
- load_level  input  1  latch level_data and level_length.
- start  input  1  begin playback.
- abort  input  1  stop playback immediately.
- loop  input  1  repeat the pattern instead of finishing.
- hold_cycles  input  PERIOD_W  cycles each note is shown.
- gap_cycles  input  PERIOD_W  silent cycles after each note.
- note_out  output  NOTE_W  current note code; 0 when not valid.
- note_valid  output  1  note_out is a sounding note.
- note_index  output  LEN_W  slot currently playing or gapping.
- busy  output  1  high in PLAY and GAP.
- done  output  1  one-cycle completion pulse.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, PLAY, GAP.
REQ-007 In IDLE, load_level=1 SHALL register level_data and level_length.
REQ-008 A level_length value greater than MAX_LEN SHALL be stored as MAX_LEN.
REQ-009 load_level SHALL be ignored in PLAY and GAP.
REQ-010 When start=1 in IDLE, the block SHALL latch hold_cycles and gap_cycles; a latched value of 0 for hold SHALL be treated as 1.
REQ-011 When load_level and start are both high in IDLE in the same cycle, playback SHALL use the newly loaded data and length.
REQ-012 When start occurs at cycle t with stored length L>0, the FSM SHALL be in PLAY from t+1 with note_index=0 and note_out=slot 0.
REQ-013 PLAY SHALL last exactly hold cycles with note_valid=1.
REQ-014 After PLAY, the FSM SHALL enter GAP for gap cycles with note_valid=0 and note_out=0; if gap=0, GAP SHALL be skipped.
REQ-015 After the GAP (or PLAY, if GAP is skipped) of slot i<L-1, the FSM SHALL enter PLAY for slot i+1 on the next cycle, with no idle cycle.
REQ-016 After the final slot L-1, if loop=1 (sampled at that cycle), the FSM SHALL re-enter PLAY at slot 0 and SHALL NOT pulse done.
REQ-017 After the final slot L-1 with loop=0, the FSM SHALL enter IDLE and done SHALL be 1 for exactly that first IDLE cycle.
REQ-018 start in IDLE with stored length 0 SHALL produce done=1 on the next cycle, with busy remaining 0 and no notes played.
REQ-019 start while busy SHALL be ignored.
REQ-020 abort=1 in any state SHALL force IDLE on the next cycle with all outputs 0 and no done pulse.
REQ-021 abort SHALL take priority over start and load_level.
REQ-022 Stored level data SHALL be preserved across abort and completion, so a repeat start replays it.
REQ-023 In IDLE, outputs SHALL be: note_out=0, note_valid=0, note_index=0, busy=0.
REQ-024 busy SHALL equal (state != IDLE), with the same registered timing as the FSM state.
REQ-025 All outputs SHALL be registered or decoded directly from registered state; no input SHALL reach an output combinationally.
REQ-026 Hold and gap counters SHALL be PERIOD_W bits wide and SHALL never wrap.

Reset
REQ-027 reset SHALL take priority over all other inputs and act only on a rising clk edge.
REQ-028 On reset, state SHALL be IDLE, stored data and length SHALL be 0, timers SHALL be 0, and all outputs SHALL be 0 from the next cycle.
REQ-029 reset asserted mid-playback SHALL end playback without a done pulse.

Verification (NOTE_W=4, MAX_LEN=4)
REQ-030 Basic playback: load 16'h1234, length 3, hold 2, gap 0, start -> note_out 1,1,2,2,3,3 on consecutive cycles, then done=1 for one cycle, then busy=0.
REQ-031 Gap: same level with gap 1 -> sequence 1,1,0,2,2,0,3,3,0 with note_valid 1,1,0,...; done asserted in the cycle after the last gap.
REQ-032 Loop: length 2, hold 1, loop=1 -> 1,2,1,2,... with no done; drop loop during slot 1 -> done asserted after that slot completes.
REQ-033 Abort and ignored commands: abort during slot 1 -> next cycle busy=0, note_out=0, done=0; start or load_level while busy -> no effect.
REQ-034 Edge cases: length 0 with start -> done next cycle, busy=0; length 7 stored as 4; hold 0 behaves as hold 1.
REQ-035 Mid-operation reset: reset during GAP -> all outputs 0 next cycle; a following start with length 0 stored yields an immediate done.

Source files
------------

// File: rtl/pattern_player.sv
// Plays a latched pattern of note codes: each slot sounds for a hold period and is
// followed by an optional silent gap, once or looping, with abort and completion pulse.
module pattern_player #(
    parameter int  NOTE_W   = 4,
    parameter int  MAX_LEN  = 8,
    parameter int  PERIOD_W = 32,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NOTE_W*MAX_LEN-1:0] level_data,
    input  logic [LEN_W-1:0]          level_length,
    input  logic                      load_level,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      loop,
    input  logic [PERIOD_W-1:0]       hold_cycles,
    input  logic [PERIOD_W-1:0]       gap_cycles,
    output logic [NOTE_W-1:0]         note_out,
    output logic                      note_valid,
    output logic [LEN_W-1:0]          note_index,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);
    localparam logic [LEN_W-1:0]    ONE_L = LEN_W'(1);
    localparam logic [LEN_W-1:0]    MAX_L = LEN_W'(MAX_LEN);

    state_t                      state_q, state_d;
    logic [NOTE_W*MAX_LEN-1:0]   data_q, data_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [PERIOD_W-1:0]         hold_q, hold_d;
    logic [PERIOD_W-1:0]         gap_q, gap_d;
    logic [PERIOD_W-1:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]            idx_q, idx_d;
    logic                        done_q, done_d;

    logic [LEN_W-1:0]            start_len_s;
    logic                        last_slot_s;
    state_t                      adv_state_s;
    logic [LEN_W-1:0]            adv_idx_s;
    logic                        adv_done_s;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_L) ? MAX_L : l;
    endfunction

    // Slot 0 lives in the most-significant note field.
    function automatic logic [NOTE_W-1:0] slot_of(input logic [NOTE_W*MAX_LEN-1:0] d,
                                                  input logic [LEN_W-1:0]          i);
        logic [NOTE_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            r = (i == LEN_W'(k)) ? d[(MAX_LEN-1-k)*NOTE_W +: NOTE_W] : r;
        end
        return r;
    endfunction

    // Where playback goes once the current slot (note plus gap) has finished.
    always_comb begin
        last_slot_s = ((idx_q + ONE_L) == len_q);
        adv_state_s = S_PLAY;
        adv_idx_s   = idx_q + ONE_L;
        adv_done_s  = 1'b0;
        if (last_slot_s) begin
            adv_idx_s = '0;
            if (loop) begin
                adv_state_s = S_PLAY;
                adv_done_s  = 1'b0;
            end else begin
                adv_state_s = S_IDLE;
                adv_done_s  = 1'b1;
            end
        end else begin
            adv_state_s = S_PLAY;
        end
    end

    // Next-state logic; abort overrides every command and suppresses done.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        len_d       = len_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        start_len_s = len_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_level) begin
                        data_d      = level_data;
                        len_d       = clamp_len(level_length);
                        start_len_s = clamp_len(level_length);
                    end else begin
                        start_len_s = len_q;
                    end
                    if (start) begin
                        hold_d = (hold_cycles == '0) ? ONE_P : hold_cycles;
                        gap_d  = gap_cycles;
                        cnt_d  = '0;
                        idx_d  = '0;
                        if (start_len_s == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (cnt_q >= hold_q - ONE_P) begin
                        cnt_d = '0;
                        if (gap_q != '0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = adv_state_s;
                            idx_d   = adv_idx_s;
                            done_d  = adv_done_s;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE_P;
                    end
                end
                S_GAP: begin
                    if (cnt_q >= gap_q - ONE_P) begin
                        cnt_d   = '0;
                        state_d = adv_state_s;
                        idx_d   = adv_idx_s;
                        done_d  = adv_done_s;
                    end else begin
                        cnt_d = cnt_q + ONE_P;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign note_out   = (state_q == S_PLAY) ? slot_of(data_q, idx_q) : '0;
    assign note_valid = (state_q == S_PLAY);
    assign note_index = idx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player with NOTE_W=4, MAX_LEN=4; expected output
// words are {note_out, note_valid, note_index, busy, done}.
module tb_pattern_player;

    localparam int NW = 4;
    localparam int ML = 4;
    localparam int PW = 32;
    localparam int LW = 3;

    logic              clk;
    logic              reset;
    logic [NW*ML-1:0]  level_data;
    logic [LW-1:0]     level_length;
    logic              load_level;
    logic              start;
    logic              abort;
    logic              loop;
    logic [PW-1:0]     hold_cycles;
    logic [PW-1:0]     gap_cycles;
    logic [NW-1:0]     note_out;
    logic              note_valid;
    logic [LW-1:0]     note_index;
    logic              busy;
    logic              done;

    int n_cmp;
    int n_err;

    pattern_player #(.NOTE_W(NW), .MAX_LEN(ML), .PERIOD_W(PW)) dut (
        .clk(clk), .reset(reset), .level_data(level_data), .level_length(level_length),
        .load_level(load_level), .start(start), .abort(abort), .loop(loop),
        .hold_cycles(hold_cycles), .gap_cycles(gap_cycles), .note_out(note_out),
        .note_valid(note_valid), .note_index(note_index), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] d, input logic [2:0] l, input logic ld,
                      input int h, input int g);
        level_data   = d;
        level_length = l;
        load_level   = ld;
        hold_cycles  = PW'(h);
        gap_cycles   = PW'(g);
        start        = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        reset = 1'b1;
        tick();
        tick();
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== 10'b0) begin
            $display("FAIL reset_outputs got %b want %b", obs, 10'b0);
            n_err++;
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [9:0] ev [0:7];
        logic [9:0] obs;
        ev = '{{4'h1,1'b1,3'd0,1'b1,1'b0}, {4'h1,1'b1,3'd0,1'b1,1'b0},
               {4'h2,1'b1,3'd1,1'b1,1'b0}, {4'h2,1'b1,3'd1,1'b1,1'b0},
               {4'h3,1'b1,3'd2,1'b1,1'b0}, {4'h3,1'b1,3'd2,1'b1,1'b0},
               {4'h0,1'b0,3'd0,1'b0,1'b1}, {4'h0,1'b0,3'd0,1'b0,1'b0}};
        go(16'h1234, 3'd3, 1'b1, 2, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            load_level = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL basic[%0d] got %b want %b", i, obs, ev[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_gap();
        logic [9:0] ev [0:10];
        logic [9:0] obs;
        ev = '{{4'h1,1'b1,3'd0,1'b1,1'b0}, {4'h1,1'b1,3'd0,1'b1,1'b0},
               {4'h0,1'b0,3'd0,1'b1,1'b0},
               {4'h2,1'b1,3'd1,1'b1,1'b0}, {4'h2,1'b1,3'd1,1'b1,1'b0},
               {4'h0,1'b0,3'd1,1'b1,1'b0},
               {4'h3,1'b1,3'd2,1'b1,1'b0}, {4'h3,1'b1,3'd2,1'b1,1'b0},
               {4'h0,1'b0,3'd2,1'b1,1'b0},
               {4'h0,1'b0,3'd0,1'b0,1'b1}, {4'h0,1'b0,3'd0,1'b0,1'b0}};
        go(16'h0000, 3'd0, 1'b0, 2, 1);
        for (int i = 0; i < 11; i++) begin
            tick();
            start = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL gap[%0d] got %b want %b", i, obs, ev[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_loop();
        logic [9:0] obs;
        logic [9:0] want;
        loop = 1'b1;
        go(16'h1234, 3'd2, 1'b1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            load_level = 1'b0;
            want = (i % 2 == 0) ? {4'h1,1'b1,3'd0,1'b1,1'b0} : {4'h2,1'b1,3'd1,1'b1,1'b0};
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== want) begin
                $display("FAIL loop[%0d] got %b want %b", i, obs, want);
                n_err++;
            end
            if (i == 5) loop = 1'b0;
        end
        tick();
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== {4'h0,1'b0,3'd0,1'b0,1'b1}) begin
            $display("FAIL loop_done got %b want %b", obs, {4'h0,1'b0,3'd0,1'b0,1'b1});
            n_err++;
        end
    endtask

    task automatic test_abort_ignore();
        logic [9:0] ev [0:2];
        logic [9:0] ev2 [0:4];
        logic [9:0] obs;
        ev  = '{{4'h5,1'b1,3'd0,1'b1,1'b0}, {4'h5,1'b1,3'd0,1'b1,1'b0},
                {4'h6,1'b1,3'd1,1'b1,1'b0}};
        ev2 = '{{4'h5,1'b1,3'd0,1'b1,1'b0}, {4'h6,1'b1,3'd1,1'b1,1'b0},
                {4'h7,1'b1,3'd2,1'b1,1'b0}, {4'h8,1'b1,3'd3,1'b1,1'b0},
                {4'h0,1'b0,3'd0,1'b0,1'b1}};
        go(16'h5678, 3'd4, 1'b1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            load_level = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL abort_pre[%0d] got %b want %b", i, obs, ev[i]);
                n_err++;
            end
        end
        abort = 1'b1;
        go(16'hFFFF, 3'd1, 1'b1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            abort = 1'b0;
            start = 1'b0;
            load_level = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== 10'b0) begin
                $display("FAIL abort_idle[%0d] got %b want %b", i, obs, 10'b0);
                n_err++;
            end
        end
        go(16'h0000, 3'd0, 1'b0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                go(16'h9ABC, 3'd1, 1'b1, 3, 3);
            end else begin
                start = 1'b0;
                load_level = 1'b0;
            end
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== ev2[i]) begin
                $display("FAIL busy_ignore[%0d] got %b want %b", i, obs, ev2[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_edges();
        logic [9:0] obs;
        logic [9:0] ev [0:4];
        logic [9:0] eh [0:2];
        ev = '{{4'h1,1'b1,3'd0,1'b1,1'b0}, {4'h2,1'b1,3'd1,1'b1,1'b0},
               {4'h3,1'b1,3'd2,1'b1,1'b0}, {4'h4,1'b1,3'd3,1'b1,1'b0},
               {4'h0,1'b0,3'd0,1'b0,1'b1}};
        eh = '{{4'hA,1'b1,3'd0,1'b1,1'b0}, {4'hB,1'b1,3'd1,1'b1,1'b0},
               {4'h0,1'b0,3'd0,1'b0,1'b1}};
        go(16'h1234, 3'd0, 1'b1, 1, 0);
        tick();
        start = 1'b0;
        load_level = 1'b0;
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== {4'h0,1'b0,3'd0,1'b0,1'b1}) begin
            $display("FAIL len0_done got %b want %b", obs, {4'h0,1'b0,3'd0,1'b0,1'b1});
            n_err++;
        end
        tick();
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== 10'b0) begin
            $display("FAIL len0_after got %b want %b", obs, 10'b0);
            n_err++;
        end
        go(16'h1234, 3'd7, 1'b1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            load_level = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL len7_clamp[%0d] got %b want %b", i, obs, ev[i]);
                n_err++;
            end
        end
        go(16'hABCD, 3'd2, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            load_level = 1'b0;
            obs = {note_out, note_valid, note_index, busy, done};
            n_cmp++;
            if (obs !== eh[i]) begin
                $display("FAIL hold0[%0d] got %b want %b", i, obs, eh[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] obs;
        go(16'h1234, 3'd3, 1'b1, 1, 2);
        tick();
        start = 1'b0;
        load_level = 1'b0;
        tick();
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== {4'h0,1'b0,3'd0,1'b1,1'b0}) begin
            $display("FAIL in_gap got %b want %b", obs, {4'h0,1'b0,3'd0,1'b1,1'b0});
            n_err++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== 10'b0) begin
            $display("FAIL mid_reset got %b want %b", obs, 10'b0);
            n_err++;
        end
        go(16'h0000, 3'd0, 1'b0, 1, 0);
        tick();
        start = 1'b0;
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== {4'h0,1'b0,3'd0,1'b0,1'b1}) begin
            $display("FAIL reset_len0_done got %b want %b", obs, {4'h0,1'b0,3'd0,1'b0,1'b1});
            n_err++;
        end
        tick();
        obs = {note_out, note_valid, note_index, busy, done};
        n_cmp++;
        if (obs !== 10'b0) begin
            $display("FAIL reset_len0_after got %b want %b", obs, 10'b0);
            n_err++;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        level_data   = 16'h0000;
        level_length = 3'd0;
        load_level   = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        loop         = 1'b0;
        hold_cycles  = 32'd0;
        gap_cycles   = 32'd0;
        test_reset();
        test_basic();
        test_gap();
        test_loop();
        test_abort_ignore();
        test_edges();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
